// File: rtl/pkt_rx_router.sv
// pkt_rx_router: demuxes LocalLink frames into per-channel slot buffers,
// posts per-channel FWFT descriptors and counts dropped frames.
module pkt_rx_router #(
  parameter int CHAN_NUMS = 8,
  parameter int CH_W = 3,
  parameter int DST_LSB = 5,
  parameter int SLOT_W = 2,
  parameter int PKT_AW = 9,
  parameter int AW = SLOT_W + PKT_AW,
  parameter int DW = 16 + 1 + (PKT_AW + 1) + SLOT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [15:0]             rx_data,
  input  logic                    rx_rem,
  input  logic                    rx_sof_n,
  input  logic                    rx_eof_n,
  input  logic                    rx_src_rdy_n,
  output logic [CHAN_NUMS-1:0]    desc_valid,
  input  logic [CHAN_NUMS-1:0]    desc_pop,
  output logic [CHAN_NUMS*DW-1:0] desc_data,
  input  logic [CHAN_NUMS-1:0]    rel_en,
  input  logic [CHAN_NUMS*AW-1:0] ram_raddr,
  output logic [CHAN_NUMS*16-1:0] ram_dout,
  output logic [15:0]             drop_cnt,
  output logic                    drop_pulse
);
  localparam int NS = 2 ** SLOT_W;
  localparam int LW = PKT_AW + 1;
  localparam int MAXK = 2 ** PKT_AW + 1;
  logic beat, sof, eof, cont, live, w1, ok_ch, acc, over, we, bad, commit;
  logic open_q, open_d, drop_q, drop_d, drop_pulse_q, drop_pulse_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [CH_W-1:0] dst_q, dst_d, dst_w, dsel, wsel;
  logic [15:0] hdr_q, hdr_d, drop_cnt_q, drop_cnt_d;
  logic [16:0] drop_sum;
  logic [1:0] ndrop;
  logic [PKT_AW-1:0] off;
  logic [DW-1:0] desc_new;
  logic [CHAN_NUMS-1:0] push, pop, rel;
  logic [SLOT_W-1:0] head_q [CHAN_NUMS];
  logic [SLOT_W-1:0] head_d [CHAN_NUMS];
  logic [SLOT_W-1:0] wp_q [CHAN_NUMS];
  logic [SLOT_W-1:0] wp_d [CHAN_NUMS];
  logic [SLOT_W-1:0] rp_q [CHAN_NUMS];
  logic [SLOT_W-1:0] rp_d [CHAN_NUMS];
  logic [SLOT_W:0] occ_q [CHAN_NUMS];
  logic [SLOT_W:0] occ_d [CHAN_NUMS];
  logic [SLOT_W:0] qn_q [CHAN_NUMS];
  logic [SLOT_W:0] qn_d [CHAN_NUMS];
  logic [15:0] dout_q [CHAN_NUMS];
  logic [15:0] dout_d [CHAN_NUMS];
  logic [DW-1:0] fifo [CHAN_NUMS][NS];
  logic [15:0] mem [CHAN_NUMS][2**AW];
  always_comb begin
    beat = !rx_src_rdy_n;
    sof = beat && !rx_sof_n;
    eof = beat && !rx_eof_n;
    cont = beat && !sof && open_q;
    live = cont && !drop_q;
    w1 = live && cnt_q == LW'(1);
    dst_w = rx_data[DST_LSB +: CH_W];
    ok_ch = int'(dst_w) < CHAN_NUMS;
    dsel = ok_ch ? dst_w : '0;
    wsel = w1 ? dsel : dst_q;
    acc = ok_ch && occ_q[dsel] < (SLOT_W+1)'(NS);
    over = live && !w1 && cnt_q == LW'(MAXK);
    we = live && (w1 ? acc : !over);
    bad = (w1 && !acc) || over;
    commit = we && eof;
    off = cnt_q[PKT_AW-1:0] - PKT_AW'(1);
    desc_new = {hdr_q, rx_rem, cnt_q + LW'(1), head_q[wsel]};
    // an abort and a runt can coincide on one sof beat, hence up to two drops
    ndrop = 2'(sof && eof) + 2'(sof && open_q && !drop_q) + 2'(bad);
    drop_sum = {1'b0, drop_cnt_q} + 17'(ndrop);
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    drop_pulse_d = ndrop != 2'd0;
    open_d = open_q;
    drop_d = drop_q;
    cnt_d = cnt_q;
    hdr_d = hdr_q;
    dst_d = dst_q;
    if (sof) begin
      open_d = !eof;
      drop_d = 1'b0;
      cnt_d = LW'(1);
      hdr_d = rx_data;
    end else if (cont) begin
      open_d = !eof;
      drop_d = drop_q || bad;
      cnt_d = (drop_q || bad) ? cnt_q : cnt_q + LW'(1);
      dst_d = w1 ? dsel : dst_q;
    end
    push = '0;
    pop = '0;
    rel = '0;
    desc_valid = '0;
    desc_data = '0;
    ram_dout = '0;
    for (int c = 0; c < CHAN_NUMS; c++) begin
      push[c] = commit && int'(wsel) == c;
      pop[c] = desc_pop[c] && qn_q[c] != '0;
      rel[c] = rel_en[c] && occ_q[c] != '0;
      head_d[c] = head_q[c] + SLOT_W'(push[c]);
      wp_d[c] = wp_q[c] + SLOT_W'(push[c]);
      rp_d[c] = rp_q[c] + SLOT_W'(pop[c]);
      occ_d[c] = occ_q[c] + (SLOT_W+1)'(push[c]) - (SLOT_W+1)'(rel[c]);
      qn_d[c] = qn_q[c] + (SLOT_W+1)'(push[c]) - (SLOT_W+1)'(pop[c]);
      dout_d[c] = mem[c][ram_raddr[c*AW +: AW]];
      desc_valid[c] = qn_q[c] != '0;
      desc_data[c*DW +: DW] = desc_valid[c] ? fifo[c][rp_q[c]] : '0;
      ram_dout[c*16 +: 16] = dout_q[c];
    end
    drop_cnt = drop_cnt_q;
    drop_pulse = drop_pulse_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      open_q <= 1'b0;
      drop_q <= 1'b0;
      cnt_q <= '0;
      hdr_q <= '0;
      dst_q <= '0;
      drop_cnt_q <= '0;
      drop_pulse_q <= 1'b0;
      head_q <= '{default: '0};
      wp_q <= '{default: '0};
      rp_q <= '{default: '0};
      occ_q <= '{default: '0};
      qn_q <= '{default: '0};
      dout_q <= '{default: '0};
    end else begin
      open_q <= open_d;
      drop_q <= drop_d;
      cnt_q <= cnt_d;
      hdr_q <= hdr_d;
      dst_q <= dst_d;
      drop_cnt_q <= drop_cnt_d;
      drop_pulse_q <= drop_pulse_d;
      head_q <= head_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      occ_q <= occ_d;
      qn_q <= qn_d;
      dout_q <= dout_d;
    end
  // storage arrays carry no reset; contents survive rst by design
  always_ff @(posedge clk) begin
    if (we) mem[wsel][{head_q[wsel], off}] <= rx_data;
    if (commit) fifo[wsel][wp_q[wsel]] <= desc_new;
  end
endmodule

// File: tb/tb_pkt_rx_router.sv
// tb_pkt_rx_router: random and directed frames checked against a frame-level
// model of slot occupancy, descriptor queues, buffer contents and drops.
module tb_pkt_rx_router;
  localparam int N = 8, AW = 11, DW = 29;
  logic clk = 1'b0, rst = 1'b1;
  logic [15:0] rx_data = '0;
  logic rx_rem = 1'b0, rx_sof_n = 1'b1, rx_eof_n = 1'b1, rx_src_rdy_n = 1'b1;
  logic [N-1:0] desc_valid, desc_pop = '0, rel_en = '0, eof_rel = '0;
  logic [N*DW-1:0] desc_data;
  logic [N*AW-1:0] ram_raddr = '0;
  logic [N*16-1:0] ram_dout;
  logic [15:0] drop_cnt;
  logic drop_pulse;
  int n_chk = 0, n_fail = 0, pulses = 0, drops = 0, drop_ev = 0;
  int occ [N];
  int head [N];
  logic [DW-1:0] expq [N][$];
  logic [15:0] shadow [N][2048];
  always #5 clk = ~clk;
  always @(negedge clk) if (drop_pulse) pulses++;
  pkt_rx_router dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_rem(rx_rem),
    .rx_sof_n(rx_sof_n), .rx_eof_n(rx_eof_n), .rx_src_rdy_n(rx_src_rdy_n),
    .desc_valid(desc_valid), .desc_pop(desc_pop), .desc_data(desc_data),
    .rel_en(rel_en), .ram_raddr(ram_raddr), .ram_dout(ram_dout),
    .drop_cnt(drop_cnt), .drop_pulse(drop_pulse)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic beat(input logic [15:0] d, input logic s, input logic e, input logic r);
    rx_data = d;
    rx_sof_n = !s;
    rx_eof_n = !e;
    rx_rem = r;
    rx_src_rdy_n = 1'b0;
    if (e) begin
      desc_pop = eof_rel;
      rel_en = eof_rel;
    end
    @(posedge clk);
    #1;
    rx_src_rdy_n = 1'b1;
    rx_sof_n = 1'b1;
    rx_eof_n = 1'b1;
    desc_pop = '0;
    rel_en = '0;
  endtask
  task automatic mk(output logic [15:0] w[$], input int ch, input int n);
    logic [15:0] x;
    w = {};
    for (int i = 0; i < n; i++) begin
      x = 16'($urandom);
      if (i == 1) x[7:5] = 3'(ch);
      w.push_back(x);
    end
  endtask
  task automatic model(input logic [15:0] w[$], input logic r);
    int n, d;
    n = w.size();
    if (n == 1) begin
      drops++;
      drop_ev++;
      return;
    end
    d = int'(w[1][7:5]);
    if (occ[d] == 4 || n > 513) begin
      drops++;
      drop_ev++;
      return;
    end
    for (int k = 1; k < n; k++) shadow[d][head[d]*512 + k - 1] = w[k];
    expq[d].push_back({w[0], r, 10'(n), 2'(head[d])});
    head[d] = (head[d] + 1) % 4;
    occ[d]++;
  endtask
  task automatic send(input logic [15:0] w[$], input logic r);
    for (int i = 0; i < w.size(); i++) beat(w[i], i == 0, i == w.size() - 1, r);
    model(w, r);
    @(negedge clk);
    #1;
    chk("drop_cnt", drop_cnt, drops > 65535 ? 65535 : drops);
    chk("drop_pulses", pulses, drop_ev);
  endtask
  task automatic abort_part(input int ch);
    logic [15:0] w[$];
    mk(w, ch, 2);
    beat(w[0], 1'b1, 1'b0, 1'b0);
    if ($urandom_range(1, 0) == 1) beat(w[1], 1'b0, 1'b0, 1'b0);
    drops++;
    drop_ev++;
  endtask
  task automatic rd(input int c, input logic [AW-1:0] a, input logic [15:0] exp);
    ram_raddr[c*AW +: AW] = a;
    @(posedge clk);
    #1;
    chk("ram_dout", ram_dout[c*16 +: 16], exp);
  endtask
  task automatic consume(input int c);
    logic [DW-1:0] e;
    int len, off;
    if (expq[c].size() == 0) begin
      chk("desc_valid_empty", desc_valid[c], 1'b0);
      return;
    end
    e = expq[c].pop_front();
    chk("desc_valid", desc_valid[c], 1'b1);
    chk("desc_data", desc_data[c*DW +: DW], e);
    len = int'(e[11:2]);
    off = $urandom_range(len - 2, 0);
    rd(c, {e[1:0], 9'(off)}, shadow[c][int'(e[1:0])*512 + off]);
    desc_pop[c] = 1'b1;
    rel_en[c] = 1'b1;
    @(posedge clk);
    #1;
    desc_pop[c] = 1'b0;
    rel_en[c] = 1'b0;
    occ[c]--;
  endtask
  task automatic drain();
    for (int c = 0; c < N; c++) while (expq[c].size() > 0) consume(c);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, desc_valid, '0);
    chk({tag, "_data"}, desc_data[63:0], '0);
    chk({tag, "_dout"}, ram_dout[63:0], '0);
    chk({tag, "_cnt"}, drop_cnt, '0);
    chk({tag, "_pulse"}, drop_pulse, 1'b0);
  endtask
  task automatic model_reset();
    drops = 0;
    for (int c = 0; c < N; c++) begin
      occ[c] = 0;
      head[c] = 0;
      expq[c].delete();
    end
  endtask
  initial begin
    logic [15:0] w[$];
    int ch, n, r;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;
    w = {16'hA5A5, 16'h0060, 16'h1111, 16'h2222};
    send(w, 1'b1);
    chk("basic_valid", desc_valid, 8'h08);
    chk("basic_desc", desc_data[3*DW +: DW], {16'hA5A5, 1'b1, 10'd4, 2'd0});
    rd(3, 11'd0, 16'h0060);
    rd(3, 11'd1, 16'h1111);
    rd(3, 11'd2, 16'h2222);
    for (int f = 0; f < 300; f++) begin
      ch = $urandom_range(N - 1, 0);
      r = $urandom_range(99, 0);
      n = r < 8 ? 1 : $urandom_range(12, 2);
      if (r >= 8 && r < 16) abort_part($urandom_range(N - 1, 0));
      mk(w, ch, n);
      send(w, 1'($urandom));
      if ($urandom_range(2, 0) == 0) consume($urandom_range(N - 1, 0));
      repeat ($urandom_range(2, 0)) begin
        @(posedge clk);
        #1;
      end
    end
    drain();
    for (int i = 0; i < 6; i++) begin
      mk(w, 1, $urandom_range(6, 2));
      send(w, 1'b0);
    end
    chk("full_valid", desc_valid[1], 1'b1);
    consume(1);
    mk(w, 1, 3);
    send(w, 1'b0);
    drain();
    mk(w, 5, 514);
    send(w, 1'b0);
    mk(w, 5, 513);
    send(w, 1'b1);
    consume(5);
    rd(5, {2'(head[5] + 3), 9'd511}, shadow[5][int'(2'(head[5] + 3))*512 + 511]);
    mk(w, 0, 4);
    send(w, 1'b0);
    mk(w, 0, 5);
    send(w, 1'b1);
    chk("conc_desc", desc_data[DW-1:0], expq[0][0]);
    eof_rel = 8'h01;
    mk(w, 0, 3);
    for (int i = 0; i < 3; i++) beat(w[i], i == 0, i == 2, 1'b0);
    eof_rel = '0;
    void'(expq[0].pop_front());
    occ[0]--;
    model(w, 1'b0);
    for (int i = 0; i < 3; i++) begin
      mk(w, 0, 2 + i);
      send(w, 1'b0);
    end
    drain();
    for (int i = 0; i < 4; i++) begin
      mk(w, i[0] ? 7 : 0, 3 + i);
      send(w, 1'(i));
      @(posedge clk);
      #1;
    end
    drain();
    rx_src_rdy_n = 1'b0;
    rx_sof_n = 1'b0;
    rx_eof_n = 1'b0;
    repeat (65537) @(posedge clk);
    #1;
    rx_src_rdy_n = 1'b1;
    rx_sof_n = 1'b1;
    rx_eof_n = 1'b1;
    drops += 65537;
    drop_ev += 65537;
    @(negedge clk);
    #1;
    chk("sat_cnt", drop_cnt, 16'hFFFF);
    chk("sat_pulses", pulses, drop_ev);
    mk(w, 4, 3);
    send(w, 1'b0);
    mk(w, 2, 4);
    beat(w[0], 1'b1, 1'b0, 1'b0);
    beat(w[1], 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("midrst");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    mk(w, 2, 4);
    send(w, 1'b1);
    chk("post_rst_valid", desc_valid, 8'h04);
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
